// File: rtl/vec_wb_pkg.sv
// vec_wb_pkg: shared types and helpers for the vector writeback controller.
// Holds the SEW and FSM state enums, default geometry and the LMUL/element-count helpers.
package vec_wb_pkg;

   localparam int VLEN_DEF       = 512;
   localparam int MAX_VLEN_DEF   = 4096;
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int VL_WIDTH_DEF   = $clog2(MAX_VLEN_DEF / 8) + 1;

   typedef enum logic [1:0] {
      SEW8  = 2'b00,
      SEW16 = 2'b01,
      SEW32 = 2'b10,
      SEW64 = 2'b11
   } sew_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_DST = 3'd1,
      MERGE  = 3'd2,
      WRITE  = 3'd3,
      ERR    = 3'd4
   } wb_state_e;

   // Only power-of-two groupings up to 8 registers exist.
   function automatic logic lmul_legal(input logic [3:0] lmul);
      return (lmul == 4'd1) || (lmul == 4'd2) || (lmul == 4'd4) || (lmul == 4'd8);
   endfunction

   // Number of SEW-wide elements held by a group of lmul registers of vlen bits.
   function automatic int elems_per_group(input int vlen, input logic [3:0] lmul, input sew_e sew);
      return (vlen * int'(lmul)) >> (3 + int'(sew));
   endfunction

endpackage

// File: rtl/vec_wb_merge.sv
// vec_wb_merge: combinational element merge of a result into the destination group.
// Byte-granular: every byte finds its element index from SEW and decides active/tail/outside.
// Optional feature: VEC_WB_TAIL_AGNOSTIC_EN writes tail elements as all-ones when i_vta=1.
module vec_wb_merge
   import vec_wb_pkg::*;
#(
   parameter int VLEN       = VLEN_DEF,
   parameter int DATA_WIDTH = MAX_VLEN_DEF,
   parameter int VL_WIDTH   = VL_WIDTH_DEF
)(
   input  logic [DATA_WIDTH-1:0] i_res,
   input  logic [DATA_WIDTH-1:0] i_dst,
   input  logic [VLEN-1:0]       i_v0,
   input  logic [VL_WIDTH-1:0]   i_vl,
   input  logic                  i_vm,
   input  logic                  i_vta,
   input  logic [3:0]            i_lmul,
   input  sew_e                  i_sew,
   output logic [DATA_WIDTH-1:0] o_data
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int VIDX_W = $clog2(VLEN);

   logic [VL_WIDTH-1:0] w_elems;
   logic [VL_WIDTH-1:0] w_vl_eff;

   // vl beyond the group size is clamped to the group size
   assign w_elems  = VL_WIDTH'(elems_per_group(VLEN, i_lmul, i_sew));
   assign w_vl_eff = (i_vl > w_elems) ? w_elems : i_vl;

   genvar gi;
   for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam logic [VL_WIDTH-1:0] BIDX = VL_WIDTH'(gi);
      logic [VL_WIDTH-1:0] w_idx;
      logic                w_in;
      logic                w_act;
      logic                w_ones;

      assign w_idx = BIDX >> i_sew;
      assign w_in  = (w_idx < w_elems);
      assign w_act = w_in && (w_idx < w_vl_eff) && (i_vm || i_v0[w_idx[VIDX_W-1:0]]);
`ifdef VEC_WB_TAIL_AGNOSTIC_EN
      assign w_ones = w_in && !(w_idx < w_vl_eff) && i_vta;
`else
      // tails stay undisturbed; vta has no effect in this build
      assign w_ones = i_vta & 1'b0;
`endif
      assign o_data[gi*8 +: 8] = w_act  ? i_res[gi*8 +: 8] :
                                 w_ones ? 8'hFF :
                                 w_in   ? i_dst[gi*8 +: 8] : 8'h00;
   end

endmodule

// File: rtl/vec_wb_ctrl.sv
// vec_wb_ctrl: writeback initiator for vec_regfile.
// Accepts one result, reads the destination group, merges active elements and issues one write.
// Mask results (res_mask_wr) go straight to a v0 write. Optional feature: VEC_WB_TAIL_AGNOSTIC_EN.
module vec_wb_ctrl
   import vec_wb_pkg::*;
#(
   parameter int VLEN       = VLEN_DEF,
   parameter int MAX_VLEN   = MAX_VLEN_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = MAX_VLEN,
   parameter int VL_WIDTH   = $clog2(MAX_VLEN / 8) + 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [DATA_WIDTH-1:0] res_data,
   input  logic [4:0]            res_vd,
   input  logic [3:0]            res_lmul,
   input  logic [1:0]            res_sew,
   input  logic [VL_WIDTH-1:0]   res_vl,
   input  logic                  res_vm,
   input  logic                  res_mask_wr,
   input  logic                  res_vta,
   input  logic [VLEN-1:0]       v0_mask_data,
   input  logic [DATA_WIDTH-1:0] dst_data,
   input  logic                  wrong_addr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  wr_en,
   output logic                  mask_wr_en,
   output logic                  wb_done,
   output logic                  wb_err
);
   wb_state_e             r_state;
   wb_state_e             w_state_next;
   logic                  w_accept;
   logic                  w_grp_legal;
   logic                  r_mask;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_res_data;
   logic [DATA_WIDTH-1:0] r_dst;
   logic [VLEN-1:0]       r_v0;
   logic [VL_WIDTH-1:0]   r_vl;
   logic                  r_vm;
   logic                  r_vta;
   logic [3:0]            r_lmul;
   sew_e                  r_sew;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_mask_data;

   // A grouped destination must be a legal LMUL, aligned to it, and fit in the 32 registers.
   // Mask writes always target v0, so vd/lmul do not constrain them.
   assign w_grp_legal = lmul_legal(res_lmul)
                     && ((res_vd & (5'(res_lmul) - 5'd1)) == 5'd0)
                     && ((6'(res_vd) + 6'(res_lmul)) <= 6'd32);

   // v0 update: bits below vl come from the result, the rest of v0 is kept; nothing above VLEN
   genvar gi;
   for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask_bit
      if (gi < VLEN) begin : g_v0
         localparam logic [VL_WIDTH-1:0] BIDX = VL_WIDTH'(gi);
         assign w_mask_data[gi] = (BIDX < res_vl) ? res_data[gi] : v0_mask_data[gi];
      end else begin : g_pad
         assign w_mask_data[gi] = 1'b0;
      end
   end

   vec_wb_merge #(
      .VLEN       (VLEN),
      .DATA_WIDTH (DATA_WIDTH),
      .VL_WIDTH   (VL_WIDTH)
   ) u_merge (
      .i_res  (r_res_data),
      .i_dst  (r_dst),
      .i_v0   (r_v0),
      .i_vl   (r_vl),
      .i_vm   (r_vm),
      .i_vta  (r_vta),
      .i_lmul (r_lmul),
      .i_sew  (r_sew),
      .o_data (w_merged)
   );

   // State register; reset abandons any result in flight
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state and Moore strobes; only one result is ever in flight
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      res_ready    = 1'b0;
      wr_en        = 1'b0;
      mask_wr_en   = 1'b0;
      wb_done      = 1'b0;
      wb_err       = 1'b0;
      case (r_state)
         IDLE: begin
            res_ready = 1'b1;
            if (res_valid) begin
               w_accept = 1'b1;
               if (res_mask_wr)       w_state_next = WRITE;
               else if (!w_grp_legal) w_state_next = ERR;
               else                   w_state_next = RD_DST;
            end
         end
         RD_DST:  w_state_next = wrong_addr ? ERR : MERGE;
         MERGE:   w_state_next = WRITE;
         WRITE: begin
            wr_en        = !r_mask;
            mask_wr_en   = r_mask;
            wb_done      = 1'b1;
            w_state_next = IDLE;
         end
         ERR: begin
            wb_err       = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Control-visible registers: write address, write data, mask-path flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         if (w_accept) begin
            r_mask  <= res_mask_wr;
            r_waddr <= res_mask_wr ? '0 : ADDR_WIDTH'(res_vd);
            if (res_mask_wr) r_wdata <= w_mask_data;
         end
         if (r_state == MERGE) r_wdata <= w_merged;
      end
   end

   // Result capture and destination snapshot; pure datapath, no reset needed
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_res_data <= res_data;
         r_vl       <= res_vl;
         r_vm       <= res_vm;
         r_vta      <= res_vta;
         r_lmul     <= res_lmul;
         r_sew      <= sew_e'(res_sew);
      end
      if (r_state == RD_DST) begin
         r_dst <= dst_data;
         r_v0  <= v0_mask_data;
      end
   end

   assign waddr = r_waddr;
   assign wdata = r_wdata;

endmodule
